// File: rtl/pfq_pkg.sv
// ---------------------------------------------------------------------------
// pfq_pkg -- shared definitions for the instruction prefetch queue.
//   pf_state_e      : fetch FSM states (FETCH / FULL / DISCARD)
//   WIN_BYTES       : bytes presented to the decoder per cycle (opcode + 2)
//   PFQ_DEPTH_DEFAULT / PFQ_RESET_PC_DEFAULT : default parameter values
//   clamp_consume() : limits decoder consumption to the bytes actually valid
// ---------------------------------------------------------------------------
package pfq_pkg;

    typedef enum logic [1:0] {
        PF_FETCH   = 2'd0,
        PF_FULL    = 2'd1,
        PF_DISCARD = 2'd2
    } pf_state_e;

    localparam int          WIN_BYTES            = 3;
    localparam int          PFQ_DEPTH_DEFAULT    = 16;
    localparam logic [15:0] PFQ_RESET_PC_DEFAULT = 16'h0000;

    function automatic logic [1:0] clamp_consume(input logic [1:0] consume,
                                                 input logic [1:0] avail);
        return (consume > avail) ? avail : consume;
    endfunction

endpackage

// File: rtl/pfq_ring.sv
// ---------------------------------------------------------------------------
// pfq_ring -- byte ring buffer behind the prefetch FSM.
//   clk, rst_n   : clock, asynchronous active-low reset
//   wr_en/wr_data: push one byte at tail (ignored when full or clearing)
//   clear        : drop all contents (head snaps to tail, count to 0)
//   consume      : bytes the decoder retires; clamped to win_cnt
//   win_bytes    : {byte2, byte1, byte0}, byte0 at head, invalid bytes read 0
//   win_cnt      : min(count, 3)
//   consume_eff  : clamped consume actually applied this cycle
//   count_next   : occupancy after this cycle's update (drives FULL decision)
// ---------------------------------------------------------------------------
module pfq_ring
    import pfq_pkg::*;
#(
    parameter int DEPTH = PFQ_DEPTH_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [7:0]                   wr_data,
    input  logic                         clear,
    input  logic [1:0]                   consume,
    output logic [8*WIN_BYTES-1:0]       win_bytes,
    output logic [1:0]                   win_cnt,
    output logic [1:0]                   consume_eff,
    output logic [$clog2(DEPTH):0]       count_next
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]       storage_reg [DEPTH];
    logic [PTR_W-1:0] head_reg;
    logic [PTR_W-1:0] tail_reg;
    logic [CNT_W-1:0] count_reg;
    logic             wr_ok;

    assign wr_ok       = wr_en && !clear && (count_reg != CNT_W'(DEPTH));
    assign win_cnt     = (count_reg >= CNT_W'(WIN_BYTES)) ? 2'(WIN_BYTES) : count_reg[1:0];
    assign consume_eff = clear ? 2'd0 : clamp_consume(consume, win_cnt);

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else begin
            count_next = count_reg + CNT_W'(wr_ok) - CNT_W'(consume_eff);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
            if (clear) begin
                // Emptying by pointer move keeps the storage untouched.
                head_reg <= tail_reg;
            end else begin
                head_reg <= head_reg + PTR_W'(consume_eff);
                if (wr_ok) begin
                    tail_reg <= tail_reg + 1'b1;
                end
            end
        end
    end

    // Storage has no reset so it maps onto distributed RAM.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            storage_reg[tail_reg] <= wr_data;
        end
    end

    // Window: combinational read at head+k; pointer add wraps at DEPTH.
    for (genvar gi = 0; gi < WIN_BYTES; gi++) begin : g_win
        logic [PTR_W-1:0] rd_ptr;
        assign rd_ptr = head_reg + PTR_W'(gi);
        assign win_bytes[8*gi +: 8] = (win_cnt > 2'(gi)) ? storage_reg[rd_ptr] : 8'h00;
    end

endmodule

// File: rtl/inst_prefetch.sv
// ---------------------------------------------------------------------------
// inst_prefetch -- instruction-byte prefetch queue feeding the 6502 decoder.
//   clk, rst_n          : clock, asynchronous active-low reset
//   flush, flush_pc     : redirect; discard queue, restart fetch at flush_pc
//   mem_req, mem_addr   : single-outstanding read request (registered)
//   mem_ack, mem_rdata  : read completion (may coincide with mem_req rising)
//   win_bytes/cnt/pc    : 3-byte decode window, byte0 at win_pc
//   consume             : bytes retired by the decoder (clamped to win_cnt)
//   stall_cnt           : present only with INST_PREFETCH_STALL_CNT_EN;
//                         counts cycles with a short window while not FULL
// ---------------------------------------------------------------------------
module inst_prefetch
    import pfq_pkg::*;
#(
    parameter int                DEPTH    = PFQ_DEPTH_DEFAULT,
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(PFQ_RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic [23:0]       win_bytes,
    output logic [1:0]        win_cnt,
    output logic [ADDR_W-1:0] win_pc,
    input  logic [1:0]        consume
`ifdef INST_PREFETCH_STALL_CNT_EN
    ,output logic [15:0]      stall_cnt
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    pf_state_e         state_reg;
    logic              mem_req_reg;
    logic [ADDR_W-1:0] fetch_pc_reg;
    logic [ADDR_W-1:0] pending_pc_reg;
    logic [ADDR_W-1:0] win_pc_reg;

    logic              ack_ok;
    logic              wr_en;
    logic              fill_ok;
    logic [1:0]        consume_eff;
    logic [CNT_W-1:0]  count_next;

    assign ack_ok = mem_req_reg && mem_ack;
    // Only a FETCH-state completion carries a byte we want; a flush in the
    // same cycle turns it into stale data.
    assign wr_en  = ack_ok && (state_reg == PF_FETCH) && !flush;

    pfq_ring #(
        .DEPTH (DEPTH)
    ) u_ring (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_data     (mem_rdata),
        .clear       (flush),
        .consume     (consume),
        .win_bytes   (win_bytes),
        .win_cnt     (win_cnt),
        .consume_eff (consume_eff),
        .count_next  (count_next)
    );

    assign fill_ok  = count_next < CNT_W'(DEPTH);
    assign mem_req  = mem_req_reg;
    assign mem_addr = fetch_pc_reg;
    assign win_pc   = win_pc_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= PF_FETCH;
            mem_req_reg    <= 1'b0;
            fetch_pc_reg   <= RESET_PC;
            pending_pc_reg <= RESET_PC;
            win_pc_reg     <= RESET_PC;
        end else begin
            if (flush) begin
                win_pc_reg <= flush_pc;
            end else begin
                win_pc_reg <= win_pc_reg + ADDR_W'(consume_eff);
            end

            case (state_reg)
                PF_FETCH: begin
                    if (flush) begin
                        mem_req_reg <= 1'b1;
                        if (mem_req_reg && !mem_ack) begin
                            // A read is in flight: keep its address until it
                            // completes, then throw the byte away.
                            state_reg      <= PF_DISCARD;
                            pending_pc_reg <= flush_pc;
                        end else begin
                            state_reg    <= PF_FETCH;
                            fetch_pc_reg <= flush_pc;
                        end
                    end else begin
                        if (ack_ok) begin
                            fetch_pc_reg <= fetch_pc_reg + 1'b1;
                        end
                        if (fill_ok) begin
                            state_reg   <= PF_FETCH;
                            mem_req_reg <= 1'b1;
                        end else begin
                            state_reg   <= PF_FULL;
                            mem_req_reg <= 1'b0;
                        end
                    end
                end
                PF_FULL: begin
                    if (flush) begin
                        state_reg    <= PF_FETCH;
                        fetch_pc_reg <= flush_pc;
                        mem_req_reg  <= 1'b1;
                    end else if (fill_ok) begin
                        state_reg   <= PF_FETCH;
                        mem_req_reg <= 1'b1;
                    end else begin
                        mem_req_reg <= 1'b0;
                    end
                end
                PF_DISCARD: begin
                    mem_req_reg <= 1'b1;
                    if (ack_ok) begin
                        state_reg    <= PF_FETCH;
                        // A flush landing on the completing cycle is newest.
                        fetch_pc_reg <= flush ? flush_pc : pending_pc_reg;
                    end else if (flush) begin
                        pending_pc_reg <= flush_pc;
                    end
                end
                default: begin
                    state_reg   <= PF_FETCH;
                    mem_req_reg <= 1'b0;
                end
            endcase
        end
    end

`ifdef INST_PREFETCH_STALL_CNT_EN
    logic [15:0] stall_cnt_reg;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
        end else if (flush) begin
            stall_cnt_reg <= '0;
        end else if ((win_cnt < 2'(WIN_BYTES)) && (state_reg != PF_FULL) &&
                     (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end
    assign stall_cnt = stall_cnt_reg;
`endif

    // Decoder must not retire bytes it was not shown; flush cycles are exempt
    // because consume is ignored there.
    consume_legal_a: assert property (@(posedge clk) disable iff (!rst_n)
        flush || (consume <= win_cnt));

endmodule

// File: tb/tb_inst_prefetch.sv
module tb_inst_prefetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [15:0] flush_pc;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic [23:0] win_bytes;
    logic [1:0]  win_cnt;
    logic [15:0] win_pc;
    logic [1:0]  consume;
`ifdef INST_PREFETCH_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    inst_prefetch #(
        .DEPTH    (16),
        .ADDR_W   (16),
        .RESET_PC (16'h0200)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .flush_pc  (flush_pc),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .win_bytes (win_bytes),
        .win_cnt   (win_cnt),
        .win_pc    (win_pc),
        .consume   (consume)
`ifdef INST_PREFETCH_STALL_CNT_EN
        ,.stall_cnt (stall_cnt)
`endif
    );

    // Memory image: the test program at 0200, a fixed hash elsewhere.
    function automatic logic [7:0] pat(input logic [15:0] a);
        case (a)
            16'h0200: return 8'hA9;
            16'h0201: return 8'h05;
            16'h0202: return 8'h8D;
            16'h0203: return 8'h00;
            16'h0204: return 8'h02;
            default:  return a[7:0] + a[15:8] + 8'h11;
        endcase
    endfunction

    function automatic logic [23:0] exp_win(input logic [15:0] pc, input int cnt);
        logic [23:0] w;
        w = 24'h0;
        for (int k = 0; k < 3; k++) begin
            if (k < cnt) w[8*k +: 8] = pat(pc + 16'(k));
        end
        return w;
    endfunction

    assign mem_rdata = pat(mem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int          e_cnt;
    logic [15:0] e_pc;
    logic [15:0] e_fpc;
    logic [15:0] old_addr;
    int          wc;
    int          c;
    int          acc;
    logic        e_req;
    int          cons_tab [20] = '{1, 2, 3, 1, 3, 2, 2, 1, 3, 3, 2, 1, 3, 3, 3, 3, 3, 3, 3, 3};
    logic [23:0] seq_win [3] = '{24'h0000A9, 24'h0005A9, 24'h8D05A9};

    initial begin
        rst_n = 1'b0; flush = 1'b0; flush_pc = 16'h0; mem_ack = 1'b0; consume = 2'd0;
        #12;
        chk("rst_mem_req",  32'(mem_req),   32'h0);
        chk("rst_mem_addr", 32'(mem_addr),  32'h0200);
        chk("rst_win_cnt",  32'(win_cnt),   32'h0);
        chk("rst_win_pc",   32'(win_pc),    32'h0200);
        chk("rst_win_bytes", 32'(win_bytes), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("req_rise", 32'(mem_req), 32'h1);
        chk("req_addr0", 32'(mem_addr), 32'h0200);
        chk("win_cnt0", 32'(win_cnt), 32'h0);

        // Sequential fetch, acks every cycle
        mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("seq_addr", 32'(mem_addr), 32'h0201 + 32'(i));
            chk("seq_cnt", 32'(win_cnt), 32'(i + 1));
            chk("seq_bytes", 32'(win_bytes), 32'(seq_win[i]));
        end
        chk("seq_pc", 32'(win_pc), 32'h0200);

        // Fill to DEPTH with no consume
        for (int i = 3; i < 16; i++) begin
            tick();
            chk("fill_req", 32'(mem_req), 32'((i + 1) < 16));
            chk("fill_addr", 32'(mem_addr), 32'h0201 + 32'(i));
        end
        chk("full_addr", 32'(mem_addr), 32'h0210);
        chk("full_cnt", 32'(win_cnt), 32'h3);
        chk("full_pc", 32'(win_pc), 32'h0200);
        tick();
        chk("full_hold_req", 32'(mem_req), 32'h0);
        chk("full_hold_addr", 32'(mem_addr), 32'h0210);
        mem_ack = 1'b0; consume = 2'd2;
        tick();
        consume = 2'd0;
        chk("refill_req", 32'(mem_req), 32'h1);
        chk("refill_addr", 32'(mem_addr), 32'h0210);
        chk("refill_pc", 32'(win_pc), 32'h0202);
        chk("refill_bytes", 32'(win_bytes), 32'h02008D);

        // Mixed consume with acks every other cycle, crossing the ring wrap
        e_cnt = 14; e_pc = 16'h0202; e_fpc = 16'h0210;
        for (int i = 0; i < 20; i++) begin
            wc    = (e_cnt < 3) ? e_cnt : 3;
            c     = (cons_tab[i] < wc) ? cons_tab[i] : wc;
            e_req = (e_cnt < 16);
            mem_ack = 1'(i % 2);
            consume = 2'(c);
            tick();
            acc   = (mem_ack && e_req) ? 1 : 0;
            e_cnt = e_cnt + acc - c;
            e_fpc = e_fpc + 16'(acc);
            e_pc  = e_pc + 16'(c);
            wc    = (e_cnt < 3) ? e_cnt : 3;
            chk("mix_pc", 32'(win_pc), 32'(e_pc));
            chk("mix_cnt", 32'(win_cnt), 32'(wc));
            chk("mix_bytes", 32'(win_bytes), 32'(exp_win(e_pc, wc)));
            chk("mix_addr", 32'(mem_addr), 32'(e_fpc));
            chk("mix_req", 32'(mem_req), 32'(e_cnt < 16));
        end
        mem_ack = 1'b0; consume = 2'd0;

        // Flush with the request outstanding; ack arrives 3 cycles later
        old_addr = e_fpc;
        flush = 1'b1; flush_pc = 16'hC000;
        tick();
        flush = 1'b0;
        chk("fl_req", 32'(mem_req), 32'h1);
        chk("fl_addr_hold", 32'(mem_addr), 32'(old_addr));
        chk("fl_cnt", 32'(win_cnt), 32'h0);
        chk("fl_pc", 32'(win_pc), 32'hC000);
        chk("fl_bytes", 32'(win_bytes), 32'h0);
        tick();
        chk("fl_addr_hold1", 32'(mem_addr), 32'(old_addr));
        tick();
        chk("fl_addr_hold2", 32'(mem_addr), 32'(old_addr));
        mem_ack = 1'b1;
        tick();
        chk("fl_addr_new", 32'(mem_addr), 32'hC000);
        chk("fl_dropped", 32'(win_cnt), 32'h0);
        tick();
        chk("fl_first_cnt", 32'(win_cnt), 32'h1);
        chk("fl_first_byte", 32'(win_bytes), 32'(exp_win(16'hC000, 1)));
        chk("fl_next_addr", 32'(mem_addr), 32'hC001);

        // Flush + ack + consume=3 in the same cycle, then address wrap
        flush = 1'b1; flush_pc = 16'hFFFE; consume = 2'd3;
        tick();
        flush = 1'b0; consume = 2'd0;
        chk("fa_addr", 32'(mem_addr), 32'hFFFE);
        chk("fa_cnt", 32'(win_cnt), 32'h0);
        chk("fa_pc", 32'(win_pc), 32'hFFFE);
        chk("fa_req", 32'(mem_req), 32'h1);
        tick();
        chk("wrap_addr1", 32'(mem_addr), 32'hFFFF);
        chk("wrap_cnt1", 32'(win_cnt), 32'h1);
        tick();
        chk("wrap_addr2", 32'(mem_addr), 32'h0000);
        tick();
        chk("wrap_addr3", 32'(mem_addr), 32'h0001);
        chk("wrap_cnt3", 32'(win_cnt), 32'h3);
        chk("wrap_bytes", 32'(win_bytes), 32'(exp_win(16'hFFFE, 3)));
        mem_ack = 1'b0; consume = 2'd2;
        tick();
        chk("wrap_pc1", 32'(win_pc), 32'h0000);
        chk("wrap_cnt4", 32'(win_cnt), 32'h1);
        chk("wrap_bytes2", 32'(win_bytes), 32'(exp_win(16'h0000, 1)));
        consume = 2'd1;
        tick();
        consume = 2'd0;
        chk("wrap_pc2", 32'(win_pc), 32'h0001);
        chk("wrap_cnt5", 32'(win_cnt), 32'h0);

        // Asynchronous reset mid-request
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req", 32'(mem_req), 32'h0);
        chk("arst_addr", 32'(mem_addr), 32'h0200);
        chk("arst_pc", 32'(win_pc), 32'h0200);
        chk("arst_cnt", 32'(win_cnt), 32'h0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
